round_robin_arbiter_32: RTL
===========================

Name: round_robin_arbiter_32

Overview:
- Shares one resource among 32 requesters using fair round-robin with locked grants.
- Each search uses an LSB-first (lowest index wins) priority encode over a rotated request mask, then falls back to an unmasked search.
- A grant is held until the owner releases it, drops its request, or exceeds a programmable hold limit.
- Sits in front of shared datapath resources (bus, encoder or converter bank) in the data-selector subsystem.

Parameters:
- NUM_REQ, 32, number of requesters. Fixed at 32 for this block.
- IDX_W, 5, width of the grant index.
- MAX_HOLD, 16, maximum cycles a grant may be held. 0 disables the timeout.

Ports:
- Clock_In  input  1  rising-edge clock.
- Reset_n_In  input  1  asynchronous, active-low reset.
- Enable_In  input  1  when low, no new grant is issued. A current grant runs to completion.
- Request_In  input  32  request vector. Bit i is requester i.
- Release_In  input  1  the current owner finishes. Sampled only in GRANT.
- Grant_Out  output  32  one-hot grant vector, registered.
- Grant_Index_Out  output  5  binary index of the owner, registered.
- Grant_Valid_Out  output  1  high while a grant is held.
- Timeout_Out  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (asynchronous, Reset_n_In=0) forces:
  - Grant_Out=0, Grant_Index_Out=0, Grant_Valid_Out=0, Timeout_Out=0;
  - Pointer=0, hold counter=0, state=IDLE.
- Pointer: 5-bit index of the highest-priority requester for the next search.
- Search:
  - Masked vector = Request_In AND (bits >= Pointer).
  - If the masked vector is nonzero, winner = lowest set index in it. Otherwise winner = lowest set index in Request_In.
  - Winner is invalid when Request_In=0.
- States: IDLE and GRANT.
- IDLE:
  - If Enable_In=1 and the winner is valid, next edge: state=GRANT, Grant_Out=1<<winner, Grant_Index_Out=winner, Grant_Valid_Out=1, counter=1.
  - Latency is one cycle from request to grant.
- GRANT: let O = current owner. An end event is any of:
  - (a) Release_In=1;
  - (b) Request_In[O]=0;
  - (c) MAX_HOLD≠0 and counter==MAX_HOLD.
- On an end event:
  - Pointer <= (O+1) mod 32. The 31→0 wrap is natural.
  - The search is re-run with the new pointer value, using the current cycle's Request_In with bit O forced to 0.
  - If Enable_In=1 and that winner is valid: new grant on the same edge, with no idle bubble and counter=1.
  - Otherwise: state=IDLE and all grant outputs are 0.
- With no end event: the grant holds and the counter increments, saturating at MAX_HOLD.
- Timeout_Out=1 for exactly the cycle after a revoke caused by (c) alone. If (a) or (b) coincides with (c), the end is treated as a normal release and Timeout_Out stays 0.
- Enable_In falling during GRANT does not revoke. After the end event the block goes to IDLE.
- Pointer updates only on an end event. IDLE cycles leave it unchanged.
- Grant_Out is always one-hot or zero. Grant_Index_Out is 0 whenever Grant_Valid_Out=0.
- Reset asserted mid-grant: all outputs clear asynchronously. After reset release, arbitration restarts from index 0.

Decomposition:
- Shared package arb_pkg:
  - constants NUM_REQ=32, IDX_W=5;
  - state enum {IDLE, GRANT};
  - function rotate_mask(ptr) returning the 32-bit mask of bits >= ptr.
- Sub-module lsb_first_encoder_32_5:
  - combinational, input Data_In[31:0];
  - outputs Index_Out[4:0] (lowest set bit) and Valid_Out (any bit set);
  - instantiated twice (masked and unmasked search).

Test Plan:
- Reset then Request_In=0x0000_0005, Enable_In=1 → next cycle Grant_Index_Out=0, Grant_Out=0x1, Grant_Valid_Out=1. Pulse Release_In → next edge Grant_Index_Out=2 with no idle cycle; Pointer=1 before that search.
- Request_In=0xFFFF_FFFF, Release_In pulsed every 2 cycles → grants 0,1,2,…,31,0 in order; each index appears exactly once per 32 grants.
- MAX_HOLD=16, Request_In=0x8000_0001, no release:
  - grant 0 for 16 cycles, then Timeout_Out=1 for one cycle;
  - grant moves to 31, which is revoked after 16 more cycles;
  - the grant then wraps to 0.
- Owner 4 (Request_In=0x10) drops Request_In[4] mid-grant → next edge Grant_Valid_Out=0, state IDLE, Pointer=5, Timeout_Out=0.
- Enable_In=0 with Request_In=0x100 → no grant ever. Enable_In=1 → grant index 8 one cycle later. Drop Enable_In during the grant → grant holds until Release_In, then IDLE.
- Assert Reset_n_In=0 mid-grant of index 12 → outputs clear immediately, without waiting for a clock edge. After release with Request_In=0x1800 → grant index 11 (Pointer reset to 0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and mask helper for the 32-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 32;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Bits at or above ptr are set; these requesters are searched before wrapping.
  function automatic logic [NUM_REQ-1:0] rotate_mask(input logic [IDX_W-1:0] ptr);
    return {NUM_REQ{1'b1}} << ptr;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/lsb_first_encoder_32_5.sv
// Combinational priority encoder: index of the lowest set bit, plus an any-bit-set flag.
module lsb_first_encoder_32_5
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] Data_In,
  output logic [IDX_W-1:0]   Index_Out,
  output logic               Valid_Out
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    Index_Out = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (Data_In[i-1]) begin
        Index_Out = IDX_W'(i - 1);
      end
    end
  end

  assign Valid_Out = |Data_In;

endmodule

// File: rtl/round_robin_arbiter_32.sv
// Round-robin arbiter for 32 requesters with locked grants, release/drop/timeout ending,
// and back-to-back re-arbitration on the ending edge.
module round_robin_arbiter_32
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               Clock_In,
  input  logic               Reset_n_In,
  input  logic               Enable_In,
  input  logic [NUM_REQ-1:0] Request_In,
  input  logic               Release_In,
  output logic [NUM_REQ-1:0] Grant_Out,
  output logic [IDX_W-1:0]   Grant_Index_Out,
  output logic               Grant_Valid_Out,
  output logic               Timeout_Out
);

  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic               valid, valid_n;
  logic               timeout, timeout_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [IDX_W-1:0]   owner_next;
  logic [IDX_W-1:0]   search_ptr;
  logic [NUM_REQ-1:0] search_req;
  logic [NUM_REQ-1:0] masked_req;
  logic [IDX_W-1:0]   masked_idx, raw_idx, winner;
  logic               masked_valid, raw_valid;

  logic               end_release, end_drop, end_limit, end_evt;

  assign owner_next = owner + IDX_W'(1);

  // While granting, the search must already see the post-release pointer and exclude
  // the outgoing owner so a hand-off lands on the same edge as the end event.
  always_comb begin
    if (state == GRANT) begin
      search_ptr = owner_next;
      search_req = Request_In & ~idx_to_onehot(owner);
    end else begin
      search_ptr = ptr;
      search_req = Request_In;
    end
  end

  assign masked_req = search_req & rotate_mask(search_ptr);

  lsb_first_encoder_32_5 u_enc_masked (
    .Data_In   (masked_req),
    .Index_Out (masked_idx),
    .Valid_Out (masked_valid)
  );

  lsb_first_encoder_32_5 u_enc_raw (
    .Data_In   (search_req),
    .Index_Out (raw_idx),
    .Valid_Out (raw_valid)
  );

  assign winner = masked_valid ? masked_idx : raw_idx;

  assign end_release = Release_In;
  assign end_drop    = ~Request_In[owner];
  assign end_limit   = (MAX_HOLD != 0) && (cnt == HOLD_LIMIT);
  assign end_evt     = end_release | end_drop | end_limit;

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    owner_n   = owner;
    valid_n   = valid;
    timeout_n = 1'b0;
    ptr_n     = ptr;
    cnt_n     = cnt;

    unique case (state)
      IDLE: begin
        if (Enable_In && raw_valid) begin
          state_n = GRANT;
          grant_n = idx_to_onehot(winner);
          owner_n = winner;
          valid_n = 1'b1;
          cnt_n   = CNT_W'(1);
        end
      end

      GRANT: begin
        if (end_evt) begin
          ptr_n     = owner_next;
          timeout_n = end_limit & ~end_release & ~end_drop;
          if (Enable_In && raw_valid) begin
            grant_n = idx_to_onehot(winner);
            owner_n = winner;
            valid_n = 1'b1;
            cnt_n   = CNT_W'(1);
          end else begin
            state_n = IDLE;
            grant_n = '0;
            owner_n = '0;
            valid_n = 1'b0;
            cnt_n   = '0;
          end
        end else if ((MAX_HOLD != 0) && (cnt != HOLD_LIMIT)) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
        owner_n = '0;
        valid_n = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      owner   <= owner_n;
      valid   <= valid_n;
      timeout <= timeout_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

  assign Grant_Out       = grant;
  assign Grant_Index_Out = owner;
  assign Grant_Valid_Out = valid;
  assign Timeout_Out     = timeout;

endmodule
